// File: rtl/axi_bridge_pkg.sv
// Shared types and constants for the data-side AXI3 bridge.
//   state_e    : bridge FSM states (3-bit encoding, 7 states)
//   BURST_INCR : AXI INCR burst encoding driven on arburst/awburst
//   ID_W_DEF   : default AXI ID width
package axi_bridge_pkg;

    localparam int unsigned ID_W_DEF   = 4;
    localparam logic [1:0]  BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StAr   = 3'd1,
        StR    = 3'd2,
        StAw   = 3'd3,
        StW    = 3'd4,
        StB    = 3'd5,
        StDone = 3'd6
    } state_e;

endpackage

// File: rtl/axi_dside_bridge_rslice.sv
// One-entry register slice for the AXI R channel of axi_dside_bridge.
// Only built when DBRIDGE_RSLICE_EN is defined; otherwise this file is empty.
//   clk_i/rst_ni             : clock, asynchronous active-low reset
//   in_valid_i/in_data_i     : beat from the AXI R channel
//   in_ready_o               : slice can accept a beat (not full)
//   out_valid_o/out_data_o   : registered beat, one cycle behind the input
//   out_ready_i              : downstream consumes the held beat
`ifdef DBRIDGE_RSLICE_EN
module axi_rslice #(
    parameter int unsigned DataW = 37
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    input  logic [DataW-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [DataW-1:0] out_data_o,
    input  logic             out_ready_i
);

    logic             valid_q, valid_d;
    logic [DataW-1:0] data_q, data_d;

    // Full only when the held beat is not being drained this cycle.
    assign in_ready_o = ~(valid_q & ~out_ready_i);

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready_o) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule
`endif

// File: rtl/axi_dside_bridge.sv
// Data-side AXI3 master adapter behind the cache/confreg mux. Converts level-held
// ram_* requests into one outstanding AXI transaction; writes win over reads.
// Optional macro DBRIDGE_RSLICE_EN: register the R channel through axi_rslice
// (rsp_* lag the AXI beat by one cycle). Undefined: combinational R pass-through.
// Ports:
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   req_*_i                 : request from mux (address, read level, write strobes,
//                             sizes/lengths, write beat data/valid/last)
//   write_begin_o           : one-cycle pulse after AW accepted
//   rsp_*_o                 : read beats, wready and bvalid back to the mux
//   ar*/r*/aw*/w*/b*        : AXI3 master channels
module axi_dside_bridge
    import axi_bridge_pkg::*;
#(
    parameter int unsigned    ID_W  = ID_W_DEF,
    parameter logic [ID_W-1:0] RD_ID = ID_W'(1),
    parameter logic [ID_W-1:0] WR_ID = ID_W'(1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [31:0]     req_addr_i,
    input  logic            req_rd_i,
    input  logic [3:0]      req_wstrb_i,
    input  logic [3:0]      req_arsize_i,
    input  logic [3:0]      req_awsize_i,
    input  logic [3:0]      req_arlen_i,
    input  logic [3:0]      req_awlen_i,
    input  logic [31:0]     req_wdata_i,
    input  logic            req_wvalid_i,
    input  logic            req_wlast_i,
    output logic            write_begin_o,
    output logic            rsp_rvalid_o,
    output logic            rsp_rlast_o,
    output logic [ID_W-1:0] rsp_rid_o,
    output logic [31:0]     rsp_rdata_o,
    output logic            rsp_wready_o,
    output logic            rsp_bvalid_o,
    output logic [ID_W-1:0] arid_o,
    output logic [31:0]     araddr_o,
    output logic [3:0]      arlen_o,
    output logic [2:0]      arsize_o,
    output logic [1:0]      arburst_o,
    output logic            arvalid_o,
    input  logic            arready_i,
    input  logic [ID_W-1:0] rid_i,
    input  logic [31:0]     rdata_i,
    input  logic [1:0]      rresp_i,
    input  logic            rlast_i,
    input  logic            rvalid_i,
    output logic            rready_o,
    output logic [ID_W-1:0] awid_o,
    output logic [31:0]     awaddr_o,
    output logic [3:0]      awlen_o,
    output logic [2:0]      awsize_o,
    output logic [1:0]      awburst_o,
    output logic            awvalid_o,
    input  logic            awready_i,
    output logic [ID_W-1:0] wid_o,
    output logic [31:0]     wdata_o,
    output logic [3:0]      wstrb_o,
    output logic            wlast_o,
    output logic            wvalid_o,
    input  logic            wready_i,
    input  logic [ID_W-1:0] bid_i,
    input  logic [1:0]      bresp_i,
    input  logic            bvalid_i,
    output logic            bready_o
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic [3:0]  strb_q, strb_d;
    logic        write_begin_q, write_begin_d;
    logic        in_r;
    logic        r_last_beat;

    // Responses and size MSBs are intentionally not consumed.
    logic unused_ok;
    assign unused_ok = ^{rresp_i, bid_i, bresp_i, req_arsize_i[3], req_awsize_i[3]};

    assign in_r = (state_q == StR);

`ifdef DBRIDGE_RSLICE_EN
    logic [ID_W+32:0] sl_data;
    logic             sl_valid;
    logic             sl_in_ready;

    axi_rslice #(
        .DataW (ID_W + 33)
    ) u_rslice (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_r & rvalid_i),
        .in_data_i   ({rid_i, rdata_i, rlast_i}),
        .in_ready_o  (sl_in_ready),
        .out_valid_o (sl_valid),
        .out_data_o  (sl_data),
        .out_ready_i (1'b1)
    );

    assign rready_o     = in_r & sl_in_ready;
    assign rsp_rvalid_o = in_r & sl_valid;
    assign rsp_rlast_o  = in_r & sl_valid & sl_data[0];
    assign rsp_rdata_o  = in_r ? sl_data[32:1] : '0;
    assign rsp_rid_o    = in_r ? sl_data[ID_W+32:33] : '0;
    assign r_last_beat  = in_r & sl_valid & sl_data[0];
`else
    assign rready_o     = in_r;
    assign rsp_rvalid_o = in_r & rvalid_i;
    assign rsp_rlast_o  = in_r & rlast_i;
    assign rsp_rdata_o  = in_r ? rdata_i : '0;
    assign rsp_rid_o    = in_r ? rid_i : '0;
    assign r_last_beat  = in_r & rvalid_i & rlast_i;
`endif

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        size_d        = size_q;
        strb_d        = strb_q;
        write_begin_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|req_wstrb_i) begin
                    state_d = StAw;
                    addr_d  = req_addr_i;
                    len_d   = req_awlen_i;
                    size_d  = req_awsize_i[2:0];
                    strb_d  = req_wstrb_i;
                end else if (req_rd_i) begin
                    state_d = StAr;
                    addr_d  = req_addr_i;
                    len_d   = req_arlen_i;
                    size_d  = req_arsize_i[2:0];
                    strb_d  = '0;
                end
            end
            StAr:   if (arready_i) state_d = StR;
            StR:    if (r_last_beat) state_d = StDone;
            StAw: begin
                if (awready_i) begin
                    state_d       = StW;
                    write_begin_d = 1'b1;
                end
            end
            StW:    if (req_wvalid_i & wready_i & req_wlast_i) state_d = StB;
            StB:    if (bvalid_i) state_d = StDone;
            // Gap cycle so a request the mux is still dropping is not re-issued.
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            len_q         <= '0;
            size_q        <= '0;
            strb_q        <= '0;
            write_begin_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            size_q        <= size_d;
            strb_q        <= strb_d;
            write_begin_q <= write_begin_d;
        end
    end

    assign write_begin_o = write_begin_q;

    assign arid_o    = RD_ID;
    assign araddr_o  = addr_q;
    assign arlen_o   = len_q;
    assign arsize_o  = size_q;
    assign arburst_o = BURST_INCR;
    assign arvalid_o = (state_q == StAr);

    assign awid_o    = WR_ID;
    assign awaddr_o  = addr_q;
    assign awlen_o   = len_q;
    assign awsize_o  = size_q;
    assign awburst_o = BURST_INCR;
    assign awvalid_o = (state_q == StAw);

    assign wid_o        = WR_ID;
    assign wdata_o      = req_wdata_i;
    assign wstrb_o      = strb_q;
    assign wlast_o      = req_wlast_i;
    assign wvalid_o     = (state_q == StW) & req_wvalid_i;
    assign rsp_wready_o = (state_q == StW) & wready_i;

    assign bready_o     = (state_q == StB);
    assign rsp_bvalid_o = (state_q == StB) & bvalid_i;

endmodule
